// File: rtl/oam_dma_arbiter.sv
// OAM DMA bus arbiter: passes CPU accesses through to the memory map and,
// on a write to DMA_REG_ADDR, stalls the CPU while copying one 256-byte page to OAM_DATA_ADDR.
module oam_dma_arbiter #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_r_en,
  input  logic [7:0]  cpu_w_data,
  output logic [7:0]  cpu_r_data,
  output logic        cpu_stall,
  output logic [15:0] bus_addr,
  output logic        bus_r_en,
  output logic [7:0]  bus_w_data,
  input  logic [7:0]  bus_r_data
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] HALT  = 3'd1;
  localparam logic [2:0] ALIGN = 3'd2;
  localparam logic [2:0] READ  = 3'd3;
  localparam logic [2:0] WRITE = 3'd4;

  logic [2:0] state;
  logic [2:0] state_next;
  logic       parity;
  logic [7:0] page;
  logic [7:0] idx;
  logic [7:0] data_latch;
  logic       trigger;

  assign trigger = (state == IDLE) && !cpu_r_en && (cpu_addr == DMA_REG_ADDR);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      parity <= 1'b0;
    end else begin
      parity <= ~parity;
    end
  end

  // HALT goes straight to READ only when the following cycle has parity 0,
  // i.e. when the current parity is 1.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (trigger) state_next = HALT;
      HALT:    state_next = parity ? READ : ALIGN;
      ALIGN:   state_next = READ;
      READ:    state_next = WRITE;
      WRITE:   state_next = (idx == 8'hFF) ? IDLE : READ;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      page       <= '0;
      idx        <= '0;
      data_latch <= '0;
    end else begin
      state <= state_next;
      if (trigger) begin
        page <= cpu_w_data;
        idx  <= '0;
      end
      if (state == READ) begin
        data_latch <= bus_r_data;
      end
      if (state == WRITE) begin
        idx <= idx + 8'd1;
      end
    end
  end

  assign cpu_stall  = (state != IDLE);
  assign cpu_r_data = bus_r_data;

  always_comb begin
    bus_addr   = cpu_addr;
    bus_r_en   = cpu_r_en;
    bus_w_data = cpu_w_data;
    case (state)
      HALT, ALIGN: begin
        bus_r_en   = 1'b1;
        bus_w_data = '0;
      end
      READ: begin
        bus_addr   = {page, idx};
        bus_r_en   = 1'b1;
        bus_w_data = '0;
      end
      WRITE: begin
        bus_addr   = OAM_DATA_ADDR;
        bus_r_en   = 1'b0;
        bus_w_data = data_latch;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Self-checking bench for oam_dma_arbiter: pass-through vector table plus
// scoreboarded DMA transfers (parity alignment, page $FF, reset abort).
module tb_oam_dma_arbiter;

  logic        clock;
  logic        reset;
  logic [15:0] cpu_addr;
  logic        cpu_r_en;
  logic [7:0]  cpu_w_data;
  logic [7:0]  cpu_r_data;
  logic        cpu_stall;
  logic [15:0] bus_addr;
  logic        bus_r_en;
  logic [7:0]  bus_w_data;
  logic [7:0]  bus_r_data;

  int total = 0;
  int bad   = 0;
  logic mem_mode = 1'b0;
  logic tb_par;

  logic [15:0] exp_rd_q[$];
  logic [7:0]  exp_wr_q[$];

  oam_dma_arbiter #(.DMA_REG_ADDR(16'h4014), .OAM_DATA_ADDR(16'h2004)) dut (
    .clock(clock), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_r_en(cpu_r_en), .cpu_w_data(cpu_w_data),
    .cpu_r_data(cpu_r_data), .cpu_stall(cpu_stall),
    .bus_addr(bus_addr), .bus_r_en(bus_r_en), .bus_w_data(bus_w_data),
    .bus_r_data(bus_r_data)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [7:0] mem_model(input logic [15:0] a, input logic m);
    if (m) return ~a[7:0];
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  always_comb bus_r_data = mem_model(bus_addr, mem_mode);

  // Reference parity: 0 in the first cycle after reset release, toggling each clock.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) tb_par <= 1'b0;
    else        tb_par <= ~tb_par;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, req, $time);
    end
  endtask

  task automatic chk_pass(input string tag);
    chk({tag, "_stall"}, 32'(cpu_stall), 32'd0);
    chk({tag, "_addr"}, 32'(bus_addr), 32'(cpu_addr));
    chk({tag, "_ren"}, 32'(bus_r_en), 32'(cpu_r_en));
    chk({tag, "_wdata"}, 32'(bus_w_data), 32'(cpu_w_data));
  endtask

  typedef struct {
    logic [15:0] addr;
    logic        r_en;
    logic [7:0]  wdata;
  } vec_t;

  task automatic run_dma(input logic [7:0] pg, input logic halt_odd, input int abort_idx);
    int stall_n = 0;
    int dummy_n = 0;
    int cyc = 0;
    bit seen_rd = 0;
    bit aborted = 0;
    logic [15:0] last_rd = '0;
    logic [15:0] ea;
    logic [7:0]  ed;

    @(posedge clock); #1;
    // HALT parity is the inverse of the trigger-cycle parity.
    if (tb_par != !halt_odd) begin
      @(posedge clock); #1;
    end
    cpu_addr = 16'h4014; cpu_r_en = 1'b0; cpu_w_data = pg;
    for (int i = 0; i < 256; i++) begin
      exp_rd_q.push_back({pg, 8'(i)});
      exp_wr_q.push_back(mem_model({pg, 8'(i)}, mem_mode));
    end
    @(negedge clock);
    chk_pass("trigger");

    while (cyc < 600) begin
      @(posedge clock); #1;
      cpu_addr = 16'h8123; cpu_r_en = 1'($urandom); cpu_w_data = 8'($urandom);
      @(negedge clock);
      cyc++;
      if (!cpu_stall) break;
      stall_n++;
      if (bus_r_en && bus_addr == cpu_addr) begin
        dummy_n++;
        chk("dummy_wdata", 32'(bus_w_data), 32'd0);
        chk("dummy_before_read", 32'(seen_rd), 32'd0);
      end else if (bus_r_en) begin
        if (!seen_rd) chk("first_read_parity", 32'(tb_par), 32'd0);
        seen_rd = 1;
        ea = (exp_rd_q.size() != 0) ? exp_rd_q.pop_front() : 16'hxxxx;
        chk("read_addr", 32'(bus_addr), 32'(ea));
        last_rd = bus_addr;
        if (abort_idx >= 0 && bus_addr == {pg, 8'(abort_idx)}) begin
          #1 reset = 1'b0;
          #1 chk("abort_stall", 32'(cpu_stall), 32'd0);
          chk("abort_ren", 32'(bus_r_en), 32'(cpu_r_en));
          cpu_addr = 16'h0100; cpu_r_en = 1'b1;
          repeat (3) begin
            @(negedge clock);
            chk("in_reset_stall", 32'(cpu_stall), 32'd0);
            chk("in_reset_no_oam", 32'(!bus_r_en && bus_addr == 16'h2004), 32'd0);
          end
          reset = 1'b1;
          repeat (6) begin
            @(posedge clock); #1;
            cpu_addr = 16'h0100 + 16'($urandom_range(0, 255)); cpu_r_en = 1'($urandom);
            cpu_w_data = 8'($urandom);
            @(negedge clock);
            chk_pass("post_reset");
          end
          exp_rd_q.delete();
          exp_wr_q.delete();
          aborted = 1;
          break;
        end
      end else begin
        chk("write_addr", 32'(bus_addr), 32'h2004);
        ed = (exp_wr_q.size() != 0) ? exp_wr_q.pop_front() : 8'hxx;
        chk("write_data", 32'(bus_w_data), 32'(ed));
      end
    end

    if (!aborted) begin
      chk("dma_timeout", 32'(cyc < 600), 32'd1);
      chk("stall_cycles", 32'(stall_n), halt_odd ? 32'd513 : 32'd514);
      chk("dummy_cycles", 32'(dummy_n), halt_odd ? 32'd1 : 32'd2);
      chk("last_read", 32'(last_rd), 32'({pg, 8'hFF}));
      chk("reads_left", 32'(exp_rd_q.size()), 32'd0);
      chk("writes_left", 32'(exp_wr_q.size()), 32'd0);
      chk_pass("after_dma");
      exp_rd_q.delete();
      exp_wr_q.delete();
    end
  endtask

  initial begin
    vec_t vecs[8];
    vecs[0] = '{16'h4014, 1'b1, 8'h02};
    vecs[1] = '{16'h4015, 1'b0, 8'h02};
    vecs[2] = '{16'h4013, 1'b0, 8'h7E};
    vecs[3] = '{16'h2004, 1'b1, 8'h11};
    vecs[4] = '{16'h0000, 1'b0, 8'hA5};
    vecs[5] = '{16'hFFFF, 1'b1, 8'h3C};
    vecs[6] = '{16'h8000, 1'b0, 8'hC3};
    vecs[7] = '{16'h4014, 1'b1, 8'hFF};

    reset = 1'b0; cpu_addr = 16'h1234; cpu_r_en = 1'b1; cpu_w_data = 8'h00;
    #23;
    chk_pass("in_reset");
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 8; i++) begin
      @(posedge clock); #1;
      cpu_addr = vecs[i].addr; cpu_r_en = vecs[i].r_en; cpu_w_data = vecs[i].wdata;
      @(negedge clock);
      chk_pass($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_rdata", i), 32'(cpu_r_data), 32'(mem_model(vecs[i].addr, 1'b0)));
    end
    @(posedge clock); #1;
    cpu_addr = 16'h0042; cpu_r_en = 1'b1;
    @(negedge clock);
    chk("no_trigger_after_table", 32'(cpu_stall), 32'd0);

    run_dma(8'h02, 1'b1, -1);
    run_dma(8'h02, 1'b0, -1);
    run_dma(8'hFF, 1'b1, -1);
    mem_mode = 1'b1;
    run_dma(8'h05, 1'b0, -1);
    mem_mode = 1'b0;
    run_dma(8'h03, 1'b1, 100);
    run_dma(8'h07, 1'b1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/oam_dma_arbiter.md
OAM_DMA_ARBITER -- requirements
Module: oam_dma_arbiter

Interface
REQ-001 SHALL have parameter DMA_REG_ADDR, default 16'h4014, the CPU write address that triggers DMA.
REQ-002 SHALL have parameter OAM_DATA_ADDR, default 16'h2004, the destination address of every DMA write.
REQ-003 SHALL have port clock  input  1  the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port cpu_addr  input  16  CPU core bus address.
REQ-006 SHALL have port cpu_r_en  input  1  CPU bus direction (1 = read, 0 = write); the CPU issues one access every cycle.
REQ-007 SHALL have port cpu_w_data  input  8  CPU write data.
REQ-008 SHALL have port cpu_r_data  output  8  read data returned to the CPU.
REQ-009 SHALL have port cpu_stall  output  1  when high, the CPU core holds all architectural and microcode state.
REQ-010 SHALL have port bus_addr  output  16  address to the memory map.
REQ-011 SHALL have port bus_r_en  output  1  memory-map direction (1 = read, 0 = write).
REQ-012 SHALL have port bus_w_data  output  8  memory-map write data.
REQ-013 SHALL have port bus_r_data  input  8  memory-map read data, valid in the same cycle as the address.

Function
REQ-014 SHALL implement the states IDLE, HALT, ALIGN, READ and WRITE.
REQ-015 SHALL, in IDLE, pass cpu_addr, cpu_r_en and cpu_w_data straight through to bus_addr, bus_r_en and bus_w_data, and hold cpu_stall = 0.
REQ-016 SHALL drive cpu_r_data = bus_r_data combinationally in every state; the CPU ignores it while stalled.
REQ-017 SHALL keep a parity bit that toggles every clock and is 0 in the first cycle after reset deassertion.
REQ-018 SHALL, in IDLE, treat a cycle with cpu_r_en = 0 and cpu_addr = DMA_REG_ADDR as a trigger: latch page = cpu_w_data, clear idx to 0, and enter HALT next cycle.
REQ-019 SHALL also pass the trigger write itself through to the bus.
REQ-020 SHALL NOT trigger on a read of DMA_REG_ADDR.
REQ-021 SHALL assert cpu_stall in HALT, ALIGN, READ and WRITE.
REQ-022 SHALL drive bus_r_en = 1, bus_addr = cpu_addr and bus_w_data = 0 in HALT and ALIGN (dummy read).
REQ-023 SHALL go from HALT to READ if the next cycle's parity is 0, otherwise to ALIGN; ALIGN SHALL always go to READ.
REQ-024 SHALL, in READ, drive bus_addr = {page, idx} and bus_r_en = 1, capture bus_r_data into a data latch at the clock edge, and go to WRITE.
REQ-025 SHALL, in WRITE, drive bus_addr = OAM_DATA_ADDR, bus_r_en = 0 and bus_w_data = the data latch.
REQ-026 SHALL, on leaving WRITE, increment idx (8-bit) and go to READ if idx was below 255, otherwise go to IDLE.
REQ-027 SHALL NOT carry the source address into the next page: page $FF reads $FF00-$FFFF only.
REQ-028 SHALL make the total stall 513 cycles when HALT falls on odd parity and 514 when it falls on even parity.
REQ-029 SHALL deassert cpu_stall in the first IDLE cycle after the final WRITE, returning to pass-through that same cycle.
REQ-030 SHALL ignore all CPU inputs except cpu_addr (used for the dummy reads) while stalled.

Reset
REQ-031 SHALL, while reset = 0, force state IDLE, cpu_stall = 0, parity = 0, page = 0, idx = 0 and data latch = 0, regardless of clock.
REQ-032 SHALL, on reset mid-DMA, abort immediately with no further DMA bus writes; the first post-reset cycle SHALL be pass-through.

Verification
REQ-033 Bench SHALL cover: CPU write $02 to $4014 with HALT on odd parity -> 513 stall cycles, bus reads $0200..$02FF each followed by a write of the same byte to $2004, then pass-through.
REQ-034 Bench SHALL cover: the same trigger with HALT on even parity -> exactly one ALIGN cycle, 514 stall cycles, first READ on parity 0.
REQ-035 Bench SHALL cover: CPU read of $4014 and CPU write to $4015 -> no stall, pass-through unchanged.
REQ-036 Bench SHALL cover: trigger with page $FF -> last read at $FFFF, no access to $0000, stall ends after idx 255 WRITE.
REQ-037 Bench SHALL cover: reset asserted during READ of idx 100 -> cpu_stall = 0 asynchronously, no further writes to $2004, IDLE after release.
REQ-038 Bench SHALL cover: memory model returning {~idx} -> 256 writes to $2004 with data $FF, $FE, ..., $00 in order.
